// File: rtl/scatter8_64_if.sv
// scatter8_64_if: producer offer, slot contents and consumer acks for the 1-to-8 scatter unit.
interface scatter8_64_if;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_sel;
    logic             in_bcast;
    logic [63:0]      in_data;
    logic [7:0][63:0] slot_data;
    logic [7:0]       slot_valid;
    logic [7:0]       slot_ack;
    logic [3:0]       occupancy;
    logic             bcast_pend;

    modport slave (
        input  in_valid, in_sel, in_bcast, in_data, slot_ack,
        output in_ready, slot_data, slot_valid, occupancy, bcast_pend
    );

    modport master (
        output in_valid, in_sel, in_bcast, in_data, slot_ack,
        input  in_ready, slot_data, slot_valid, occupancy, bcast_pend
    );
endinterface

// File: rtl/scatter8_64.sv
// scatter8_64: registered 1-to-8 scatter of a 64-bit word into eight acknowledged holding slots.
module scatter8_64 (
    input logic          clk,
    input logic          reset,
    scatter8_64_if.slave bus
);
    logic [7:0][63:0] r_data;
    logic [7:0]       r_valid;
    logic [3:0]       r_occ;
    logic [7:0]       w_free;
    logic [7:0]       w_wr;
    logic [7:0]       w_nvalid;
    logic             w_ready;
    logic             w_xfer;
    logic [3:0]       w_ncnt;

    // A slot being acked this cycle is free, so a refill can pass straight through.
    always_comb begin
        w_free   = ~r_valid | bus.slot_ack;
        w_ready  = ~reset & (bus.in_bcast ? &w_free : w_free[bus.in_sel]);
        w_xfer   = bus.in_valid & w_ready;
        w_wr     = w_xfer ? (bus.in_bcast ? 8'hFF : 8'h01 << bus.in_sel) : 8'h00;
        w_nvalid = w_wr | (r_valid & ~bus.slot_ack);
        w_ncnt   = 4'd0;
        for (int i = 0; i < 8; i++) w_ncnt = w_ncnt + {3'd0, w_nvalid[i]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 8'h00;
            r_occ   <= 4'd0;
            r_data  <= '0;
        end else begin
            r_valid <= w_nvalid;
            r_occ   <= w_ncnt;
            for (int i = 0; i < 8; i++) if (w_wr[i]) r_data[i] <= bus.in_data;
        end
    end

    assign bus.in_ready   = w_ready;
    assign bus.bcast_pend = bus.in_valid & bus.in_bcast & ~w_ready;
    assign bus.slot_data  = r_data;
    assign bus.slot_valid = r_valid;
    assign bus.occupancy  = r_occ;
endmodule

// File: tb/tb_scatter8_64.sv
// tb_scatter8_64: directed vectors with hand-computed expectations for scatter8_64.
module tb_scatter8_64;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    scatter8_64_if bus();
    scatter8_64 dut (.clk(clk), .reset(reset), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [2:0] sel, input logic bc, input logic [63:0] d);
        bus.in_valid = v;
        bus.in_sel   = sel;
        bus.in_bcast = bc;
        bus.in_data  = d;
    endtask

    initial begin
        reset = 1'b1;
        bus.slot_ack = 8'h00;
        offer(1'b1, 3'd3, 1'b0, 64'h3333_3333_3333_3333);
        for (int c = 0; c < 2; c++) begin
            step();
            check("rst_valid", {56'd0, bus.slot_valid}, 64'h00);
            check("rst_occ", {60'd0, bus.occupancy}, 64'd0);
            check("rst_ready", {63'd0, bus.in_ready}, 64'd0);
            check("rst_bpend", {63'd0, bus.bcast_pend}, 64'd0);
        end
        check("rst_data3", bus.slot_data[3], 64'h0);
        reset = 1'b0;
        offer(1'b0, 3'd0, 1'b0, 64'h0);
        step();
        check("idle_valid", {56'd0, bus.slot_valid}, 64'h00);

        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 3'(i), 1'b0, 64'hA5A5_0000_0000_0001 + 64'(i));
            #1;
            check("fill_ready", {63'd0, bus.in_ready}, 64'd1);
            step();
        end
        offer(1'b0, 3'd0, 1'b0, 64'h0);
        check("fill_valid", {56'd0, bus.slot_valid}, 64'hFF);
        check("fill_occ", {60'd0, bus.occupancy}, 64'd8);
        for (int i = 0; i < 8; i++) check("fill_data", bus.slot_data[i], 64'hA5A5_0000_0000_0001 + 64'(i));
        offer(1'b1, 3'd2, 1'b0, 64'hBAD0_BAD0_BAD0_BAD0);
        #1;
        check("full_ready", {63'd0, bus.in_ready}, 64'd0);
        step();
        check("full_data2", bus.slot_data[2], 64'hA5A5_0000_0000_0003);
        offer(1'b0, 3'd0, 1'b0, 64'h0);

        bus.slot_ack = 8'h20;
        offer(1'b1, 3'd5, 1'b0, 64'h1111);
        step();
        check("pre_data5", bus.slot_data[5], 64'h1111);
        offer(1'b1, 3'd5, 1'b0, 64'h2222);
        #1;
        check("ar_ready", {63'd0, bus.in_ready}, 64'd1);
        step();
        bus.slot_ack = 8'h00;
        offer(1'b0, 3'd0, 1'b0, 64'h0);
        check("ar_valid5", {63'd0, bus.slot_valid[5]}, 64'd1);
        check("ar_data5", bus.slot_data[5], 64'h2222);
        check("ar_occ", {60'd0, bus.occupancy}, 64'd8);

        bus.slot_ack = 8'hBF;
        step();
        bus.slot_ack = 8'h00;
        check("drain_valid", {56'd0, bus.slot_valid}, 64'h40);
        check("drain_occ", {60'd0, bus.occupancy}, 64'd1);
        offer(1'b1, 3'd0, 1'b1, 64'hDEAD_BEEF);
        #1;
        check("bs_ready", {63'd0, bus.in_ready}, 64'd0);
        check("bs_bpend", {63'd0, bus.bcast_pend}, 64'd1);
        step();
        check("bs_valid", {56'd0, bus.slot_valid}, 64'h40);
        check("bs_data0", bus.slot_data[0], 64'hA5A5_0000_0000_0001);
        bus.slot_ack = 8'h40;
        #1;
        check("bs_ack_ready", {63'd0, bus.in_ready}, 64'd1);
        check("bs_ack_bpend", {63'd0, bus.bcast_pend}, 64'd0);
        step();
        bus.slot_ack = 8'h00;
        offer(1'b0, 3'd0, 1'b0, 64'h0);
        check("bc_valid", {56'd0, bus.slot_valid}, 64'hFF);
        check("bc_occ", {60'd0, bus.occupancy}, 64'd8);
        for (int i = 0; i < 8; i++) check("bc_data", bus.slot_data[i], 64'hDEAD_BEEF);

        bus.slot_ack = 8'h02;
        step();
        check("ack1_valid", {56'd0, bus.slot_valid}, 64'hFD);
        step();
        bus.slot_ack = 8'h00;
        check("spur_valid", {56'd0, bus.slot_valid}, 64'hFD);
        check("spur_occ", {60'd0, bus.occupancy}, 64'd7);
        check("spur_data1", bus.slot_data[1], 64'hDEAD_BEEF);

        bus.slot_ack = 8'hEE;
        step();
        bus.slot_ack = 8'h00;
        check("mid_pre_valid", {56'd0, bus.slot_valid}, 64'h11);
        check("mid_pre_occ", {60'd0, bus.occupancy}, 64'd2);
        reset = 1'b1;
        offer(1'b1, 3'd7, 1'b0, 64'h7777);
        #1;
        check("mid_ready", {63'd0, bus.in_ready}, 64'd0);
        step();
        check("mid_valid", {56'd0, bus.slot_valid}, 64'h00);
        check("mid_occ", {60'd0, bus.occupancy}, 64'd0);
        check("mid_data7", bus.slot_data[7], 64'h0);
        check("mid_data0", bus.slot_data[0], 64'h0);
        reset = 1'b0;
        offer(1'b0, 3'd0, 1'b0, 64'h0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
